// File: rtl/mmcm_ps_pkg.sv
// Shared types and helpers for the MMCM fine-phase-shift controller.
// Holds the FSM encoding, the ps_err bit positions and signed saturation.
package mmcm_ps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_STEP = 2'd2,
        ST_WAIT = 2'd3
    } ps_state_t;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_RANGE   = 1;

    // Clamp a wide signed value into the range of a width-bit two's-complement number.
    function automatic int sat_signed(input int val, input int width);
        int hi;
        int lo;
        hi = (1 <<< (width - 1)) - 1;
        lo = -(1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/mmcm_ps_dir.sv
// Step direction and post-step phase for the shortest walk from cur to target.
// Purely combinational; linear mode when PHASE_MOD is 0, modular otherwise.
module mmcm_ps_dir #(
    parameter int PHASE_WIDTH = 8,
    parameter int PHASE_MOD   = 0
) (
    input  logic [PHASE_WIDTH-1:0] target,
    input  logic [PHASE_WIDTH-1:0] cur,
    output logic                   at_target,
    output logic                   inc,
    output logic [PHASE_WIDTH-1:0] next_phase
);

    localparam int W = PHASE_WIDTH;
    localparam logic signed [W:0] MOD_S  = (W+1)'(PHASE_MOD);
    localparam logic signed [W:0] HALF_S = (W+1)'(PHASE_MOD / 2);
    localparam logic [W-1:0] TOP_PHASE   = W'((PHASE_MOD > 0) ? PHASE_MOD - 1 : 0);

    logic signed [W:0] diff;
    logic signed [W:0] diff_norm;

    always_comb begin
        diff       = $signed({target[W-1], target}) - $signed({cur[W-1], cur});
        diff_norm  = diff;
        at_target  = (diff == '0);
        inc        = 1'b0;
        next_phase = cur;
        if (PHASE_MOD == 0) begin
            inc        = ~diff[W];
            next_phase = inc ? cur + 1'b1 : cur - 1'b1;
        end else begin
            // Forward distance around the ring; a tie goes the incrementing way.
            if (diff[W]) begin
                diff_norm = diff + MOD_S;
            end
            inc = (diff_norm <= HALF_S);
            if (inc) begin
                next_phase = (cur == TOP_PHASE) ? '0 : cur + 1'b1;
            end else begin
                next_phase = (cur == '0) ? TOP_PHASE : cur - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmcm_ps_ctrl.sv
// MMCME2 fine-phase-shift controller: walks ps_dout to the requested phase one
// PSEN step at a time, committing each step only on a confirmed PSDONE.
module mmcm_ps_ctrl
    import mmcm_ps_pkg::*;
#(
    parameter int PHASE_WIDTH    = 8,
    parameter int PHASE_MOD      = 0,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                   psclk,
    input  logic                   rst,
    input  logic                   locked,
    input  logic                   ps_we,
    input  logic                   ps_rel,
    input  logic [PHASE_WIDTH-1:0] ps_din,
    output logic                   ps_ready,
    output logic [PHASE_WIDTH-1:0] ps_dout,
    output logic [1:0]             ps_err,
    output logic                   psen,
    output logic                   psincdec,
    input  logic                   psdone
);

    localparam int W        = PHASE_WIDTH;
    localparam int MOD_SAFE = (PHASE_MOD > 0) ? PHASE_MOD : 1;
    localparam int TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    ps_state_t     state_reg;
    logic [W-1:0]  target_reg;
    logic [W-1:0]  dout_reg;
    logic [1:0]    err_reg;
    logic          psen_reg;
    logic          incdec_reg;
    logic          psdone_reg;
    logic [TW-1:0] tmo_reg;

    logic [W-1:0]  req_target;
    logic [1:0]    req_err;
    logic          req_reject;
    int            sum_int;
    int            sat_int;
    int            mod_int;

    logic          at_target;
    logic          dir_inc;
    logic [W-1:0]  next_phase;

    // Target for a request presented in IDLE, with its range error flag.
    always_comb begin
        req_target = ps_din;
        req_err    = '0;
        req_reject = 1'b0;
        sum_int    = int'($signed(dout_reg)) + int'($signed(ps_din));
        sat_int    = sat_signed(sum_int, W);
        mod_int    = sum_int % MOD_SAFE;
        if (mod_int < 0) begin
            mod_int = mod_int + MOD_SAFE;
        end
        if (PHASE_MOD == 0) begin
            if (ps_rel) begin
                req_target         = sat_int[W-1:0];
                req_err[ERR_RANGE] = (sat_int != sum_int);
            end
        end else if (ps_rel) begin
            req_target = mod_int[W-1:0];
        end else if (int'(ps_din) >= PHASE_MOD) begin
            req_reject         = 1'b1;
            req_err[ERR_RANGE] = 1'b1;
        end
    end

    mmcm_ps_dir #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .PHASE_MOD   (PHASE_MOD)
    ) u_dir (
        .target     (target_reg),
        .cur        (dout_reg),
        .at_target  (at_target),
        .inc        (dir_inc),
        .next_phase (next_phase)
    );

    always_ff @(posedge psclk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            target_reg <= '0;
            dout_reg   <= '0;
            err_reg    <= '0;
            psen_reg   <= 1'b0;
            incdec_reg <= 1'b0;
            psdone_reg <= 1'b0;
            tmo_reg    <= '0;
        end else if (!locked) begin
            // A relock restores the static phase, so the count restarts at zero.
            state_reg  <= ST_IDLE;
            target_reg <= '0;
            dout_reg   <= '0;
            psen_reg   <= 1'b0;
            incdec_reg <= 1'b0;
            psdone_reg <= 1'b0;
            tmo_reg    <= '0;
        end else begin
            psen_reg   <= 1'b0;
            psdone_reg <= psdone && (state_reg == ST_WAIT);
            case (state_reg)
                ST_IDLE: begin
                    if (ps_we) begin
                        err_reg <= req_err;
                        if (!req_reject) begin
                            target_reg <= req_target;
                            state_reg  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (at_target) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        psen_reg   <= 1'b1;
                        incdec_reg <= dir_inc;
                        state_reg  <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    tmo_reg   <= TMO_LOAD;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (psdone_reg) begin
                        dout_reg  <= next_phase;
                        state_reg <= ST_CALC;
                    end else if (tmo_reg == '0) begin
                        err_reg[ERR_TIMEOUT] <= 1'b1;
                        state_reg            <= ST_IDLE;
                    end else begin
                        tmo_reg <= tmo_reg - 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ps_ready = (state_reg == ST_IDLE) && locked;
    assign ps_dout  = dout_reg;
    assign ps_err   = err_reg;
    assign psen     = psen_reg;
    assign psincdec = incdec_reg;

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// Bench for mmcm_ps_ctrl: one linear and one modular (56-step) instance, each
// driven against an MMCM model that returns PSDONE 12 cycles after PSEN.
module tb_mmcm_ps_ctrl;

    localparam int W   = 8;
    localparam int TMO = 20;
    localparam int MOD = 56;

    typedef struct {
        int         unit;
        logic       rel;
        logic [7:0] din;
        logic [7:0] dout;
        logic [1:0] err;
        int         n_inc;
        int         n_dec;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic [1:0] err;
        int         n_inc;
        int         n_dec;
    } exp_t;

    logic       psclk = 1'b0;
    logic       rst;
    logic       locked   [2];
    logic       ps_we    [2];
    logic       ps_rel   [2];
    logic [7:0] ps_din   [2];
    logic       ps_ready [2];
    logic [7:0] ps_dout  [2];
    logic [1:0] ps_err   [2];
    logic       psen     [2];
    logic       psincdec [2];
    logic       psdone   [2];

    int   pend      [2] = '{0, 0};
    int   n_inc     [2] = '{0, 0};
    int   n_dec     [2] = '{0, 0};
    int   step_no   [2] = '{0, 0};
    logic prev_psen [2] = '{1'b0, 1'b0};
    int   drop_at   [2];
    int   psen_consec   = 0;
    int   psen_unlocked = 0;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[16];

    mmcm_ps_ctrl #(.PHASE_WIDTH(W), .PHASE_MOD(0), .TIMEOUT_CYCLES(TMO)) dut_lin (
        .psclk(psclk), .rst(rst), .locked(locked[0]), .ps_we(ps_we[0]), .ps_rel(ps_rel[0]),
        .ps_din(ps_din[0]), .ps_ready(ps_ready[0]), .ps_dout(ps_dout[0]), .ps_err(ps_err[0]),
        .psen(psen[0]), .psincdec(psincdec[0]), .psdone(psdone[0])
    );

    mmcm_ps_ctrl #(.PHASE_WIDTH(W), .PHASE_MOD(MOD), .TIMEOUT_CYCLES(TMO)) dut_mod (
        .psclk(psclk), .rst(rst), .locked(locked[1]), .ps_we(ps_we[1]), .ps_rel(ps_rel[1]),
        .ps_din(ps_din[1]), .ps_ready(ps_ready[1]), .ps_dout(ps_dout[1]), .ps_err(ps_err[1]),
        .psen(psen[1]), .psincdec(psincdec[1]), .psdone(psdone[1])
    );

    initial forever #5 psclk = ~psclk;

    // MMCM model: PSDONE pulse 12 cycles after each PSEN, unless that step is dropped.
    always @(posedge psclk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            psdone[i] = 1'b0;
            if (pend[i] > 0) begin
                pend[i] = pend[i] - 1;
                if (pend[i] == 0) psdone[i] = 1'b1;
            end
            if (psen[i]) begin
                step_no[i] = step_no[i] + 1;
                if (psincdec[i]) n_inc[i] = n_inc[i] + 1;
                else n_dec[i] = n_dec[i] + 1;
                if (!locked[i]) psen_unlocked = psen_unlocked + 1;
                if (prev_psen[i]) psen_consec = psen_consec + 1;
                if (step_no[i] != drop_at[i]) pend[i] = 12;
            end
            prev_psen[i] = psen[i];
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge psclk);
        #1;
    endtask

    task automatic compare_txn(input int u, input string tag, input int got_inc, input int got_dec);
        exp_t x;
        x = sb.pop_front();
        check({tag, "_dout"}, int'(ps_dout[u]), int'(x.dout));
        check({tag, "_err"}, int'(ps_err[u]), int'(x.err));
        check({tag, "_inc"}, got_inc, x.n_inc);
        check({tag, "_dec"}, got_dec, x.n_dec);
        $display("txn %s unit=%0d dout=%02h err=%b inc=%0d dec=%0d", tag, u, ps_dout[u],
                 ps_err[u], got_inc, got_dec);
    endtask

    // Issue one request, inject a dropped ps_we while busy, then score the result.
    task automatic run_req(input int u, input logic rel, input logic [7:0] din, input exp_t e,
                           input string tag);
        int b_inc;
        int b_dec;
        bit done;
        sb.push_back(e);
        b_inc = n_inc[u];
        b_dec = n_dec[u];
        ps_rel[u] = rel;
        ps_din[u] = din;
        ps_we[u]  = 1'b1;
        tick();
        done = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            ps_we[u] = 1'b0;
            if (ps_ready[u]) begin
                done = 1'b1;
                break;
            end
            if (k == 4) begin
                ps_we[u]  = 1'b1;
                ps_din[u] = 8'h33;
            end
            tick();
        end
        ps_we[u] = 1'b0;
        check({tag, "_done"}, int'(done), 1);
        compare_txn(u, tag, n_inc[u] - b_inc, n_dec[u] - b_dec);
    endtask

    initial begin
        int   psen_t [4];
        int   np;
        int   err_t;
        int   b_inc;
        int   b_sum;
        bit   done;
        exp_t e;

        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   psen_t [4];
        int   np;
        int   err_t;
        int   b_inc;
        int   b_sum;
        bit   done;
        exp_t e;

        vecs[0]  = '{0, 1'b0, 8'h05, 8'h05, 2'b00,   5,   0};
        vecs[1]  = '{0, 1'b0, 8'hFD, 8'hFD, 2'b00,   0,   8};
        vecs[2]  = '{0, 1'b1, 8'h7F, 8'h7C, 2'b00, 127,   0};
        vecs[3]  = '{0, 1'b1, 8'h64, 8'h7F, 2'b10,   3,   0};
        vecs[4]  = '{0, 1'b1, 8'h80, 8'hFF, 2'b00,   0, 128};
        vecs[5]  = '{0, 1'b1, 8'h80, 8'h80, 2'b10,   0, 127};
        vecs[6]  = '{0, 1'b0, 8'h80, 8'h80, 2'b00,   0,   0};
        vecs[7]  = '{1, 1'b0, 8'd2,  8'd2,  2'b00,   2,   0};
        vecs[8]  = '{1, 1'b0, 8'd50, 8'd50, 2'b00,   0,   8};
        vecs[9]  = '{1, 1'b0, 8'd0,  8'd0,  2'b00,   6,   0};
        vecs[10] = '{1, 1'b0, 8'd28, 8'd28, 2'b00,  28,   0};
        vecs[11] = '{1, 1'b1, 8'hE2, 8'd54, 2'b00,  26,   0};
        vecs[12] = '{1, 1'b1, 8'd100, 8'd42, 2'b00,  0,  12};
        vecs[13] = '{1, 1'b0, 8'd56, 8'd42, 2'b10,   0,   0};
        vecs[14] = '{1, 1'b0, 8'd42, 8'd42, 2'b00,   0,   0};
        vecs[15] = '{1, 1'b0, 8'd0,  8'd0,  2'b00,  14,   0};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            locked[i]  = 1'b0;
            ps_we[i]   = 1'b0;
            ps_rel[i]  = 1'b0;
            ps_din[i]  = '0;
            drop_at[i] = 0;
        end
        repeat (3) @(posedge psclk);
        #1;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_dout%0d", i), int'(ps_dout[i]), 0);
            check($sformatf("rst_err%0d", i), int'(ps_err[i]), 0);
            check($sformatf("rst_psen%0d", i), int'(psen[i]), 0);
            check($sformatf("rst_incdec%0d", i), int'(psincdec[i]), 0);
            check($sformatf("rst_ready_unlocked%0d", i), int'(ps_ready[i]), 0);
        end

        // Requests before lock are dropped.
        ps_din[0] = 8'h09;
        ps_we[0]  = 1'b1;
        tick();
        ps_we[0] = 1'b0;
        tick();
        check("unlocked_we_dout", int'(ps_dout[0]), 0);

        locked[0] = 1'b1;
        locked[1] = 1'b1;
        #1;
        check("ready_lin", int'(ps_ready[0]), 1);
        check("ready_mod", int'(ps_ready[1]), 1);
        tick();

        for (int v = 0; v < 16; v++) begin
            e = '{vecs[v].dout, vecs[v].err, vecs[v].n_inc, vecs[v].n_dec};
            run_req(vecs[v].unit, vecs[v].rel, vecs[v].din, e, $sformatf("vec%0d", v));
        end

        // PSDONE lost on the third step: timeout with two steps committed.
        sb.push_back('{8'd2, 2'b01, 3, 0});
        b_inc      = n_inc[1];
        drop_at[1] = step_no[1] + 3;
        ps_rel[1]  = 1'b0;
        ps_din[1]  = 8'd5;
        ps_we[1]   = 1'b1;
        tick();
        ps_we[1] = 1'b0;
        np    = 0;
        err_t = -1;
        done  = 1'b0;
        for (int k = 1; k < 400; k++) begin
            if (psen[1] && np < 4) begin
                psen_t[np] = k;
                np++;
            end
            if (ps_err[1][0] && err_t < 0) err_t = k;
            if (ps_ready[1]) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("tmo_done", int'(done), 1);
        check("tmo_npsen", np, 3);
        if (np >= 3) begin
            check("first_psen_latency", psen_t[0], 2);
            check("step_period", psen_t[1] - psen_t[0], 15);
            check("tmo_latency", err_t - psen_t[2], TMO + 1);
        end
        compare_txn(1, "timeout", n_inc[1] - b_inc, 0);

        e = '{8'd2, 2'b00, 0, 0};
        run_req(1, 1'b0, 8'd2, e, "err_clear");

        // Lock lost while waiting for PSDONE, then relock with a late PSDONE.
        b_inc     = n_inc[0];
        ps_rel[0] = 1'b0;
        ps_din[0] = 8'h94;
        ps_we[0]  = 1'b1;
        tick();
        ps_we[0] = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (psen[0]) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("lock_first_psen", int'(done), 1);
        repeat (5) tick();
        locked[0] = 1'b0;
        tick();
        check("unlock_dout", int'(ps_dout[0]), 0);
        check("unlock_ready", int'(ps_ready[0]), 0);
        check("unlock_psen", int'(psen[0]), 0);
        b_sum = n_inc[0] + n_dec[0];
        repeat (2) tick();
        locked[0] = 1'b1;
        tick();
        check("relock_ready", int'(ps_ready[0]), 1);
        repeat (10) tick();
        check("late_psdone_dout", int'(ps_dout[0]), 0);
        check("late_psdone_ready", int'(ps_ready[0]), 1);
        check("abort_no_psen", n_inc[0] + n_dec[0], b_sum);
        $display("txn lock_drop unit=0 dout=%02h steps=%0d", ps_dout[0], n_inc[0] - b_inc);

        // Asynchronous reset mid-step.
        ps_din[0] = 8'd10;
        ps_we[0]  = 1'b1;
        tick();
        ps_we[0] = 1'b0;
        np = 0;
        for (int k = 0; k < 100; k++) begin
            if (psen[0]) np++;
            if (np == 2) break;
            tick();
        end
        check("rst_pre_psen", np, 2);
        check("rst_pre_dout", int'(ps_dout[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dout_lin", int'(ps_dout[0]), 0);
        check("arst_psen", int'(psen[0]), 0);
        check("arst_incdec", int'(psincdec[0]), 0);
        check("arst_err", int'(ps_err[0]), 0);
        check("arst_ready", int'(ps_ready[0]), 1);
        check("arst_dout_mod", int'(ps_dout[1]), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", int'(ps_ready[0]), 1);
        $display("txn async_rst unit=0 dout=%02h", ps_dout[0]);

        check("psen_consecutive", psen_consec, 0);
        check("psen_while_unlocked", psen_unlocked, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
